// File: rtl/dmem_line_responder.sv
// Single-line data-cache responder: serves core word accesses from one buffered line, with write-back/fill to line memory.
// Optional DMEM_RESP_STATS_EN adds hit_count/miss_count outputs.
module dmem_line_responder #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dmem_read,
  input  logic                     dmem_write,
  input  logic [31:0]              dmem_address,
  input  logic [31:0]              dmem_wdata,
  input  logic [3:0]               dmem_wmask,
  output logic [31:0]              dmem_rdata,
  output logic                     dmem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [31:0]              pmem_address,
  output logic [32*LINE_WORDS-1:0] pmem_wdata,
  input  logic [32*LINE_WORDS-1:0] pmem_rdata,
  input  logic                     pmem_resp
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
  localparam int unsigned OFFSET_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned WSEL_W    = OFFSET_W - 2;
  localparam int unsigned TAG_W     = 32 - OFFSET_W;
  localparam int unsigned BASE_W    = WSEL_W + 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LINE_BITS-1:0] line_data_q, line_data_d;
  logic [TAG_W-1:0]     line_tag_q, line_tag_d;
  logic                 valid_q, valid_d;
  logic                 dirty_q, dirty_d;

  logic [31:0]          dmem_rdata_d;
  logic                 dmem_resp_d;
  logic                 pmem_read_d;
  logic                 pmem_write_d;
  logic [31:0]          pmem_address_d;
  logic [LINE_BITS-1:0] pmem_wdata_d;

  logic [TAG_W-1:0]     req_tag;
  logic [WSEL_W-1:0]    word_sel;
  logic [BASE_W-1:0]    bit_base;
  logic [31:0]          cur_word;
  logic [31:0]          merged_word;
  logic                 req;
  logic                 hit;
  logic                 unused_addr_bits;

`ifdef DMEM_RESP_STATS_EN
  logic                 retry_q, retry_d;
  logic                 hit_inc;
  logic                 miss_inc;
`endif

  assign req_tag          = dmem_address[31:OFFSET_W];
  assign word_sel         = dmem_address[OFFSET_W-1:2];
  assign bit_base         = {word_sel, 5'd0};
  assign cur_word         = line_data_q[bit_base +: 32];
  assign req              = dmem_read | dmem_write;
  assign hit              = valid_q && (line_tag_q == req_tag);
  assign unused_addr_bits = ^dmem_address[1:0];

  // Byte-enable merge of the write data into the currently selected word
  always_comb begin
    merged_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (dmem_wmask[b]) begin
        merged_word[8*b +: 8] = dmem_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    line_data_d    = line_data_q;
    line_tag_d     = line_tag_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    dmem_rdata_d   = dmem_rdata;
    dmem_resp_d    = 1'b0;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
`ifdef DMEM_RESP_STATS_EN
    retry_d        = retry_q;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read and write is serviced as a write
            if (dmem_write) begin
              line_data_d[bit_base +: 32] = merged_word;
              dirty_d                     = 1'b1;
            end else begin
              dmem_rdata_d = cur_word;
            end
            dmem_resp_d = 1'b1;
            state_d     = RESP;
`ifdef DMEM_RESP_STATS_EN
            hit_inc = ~retry_q;
            retry_d = 1'b0;
`endif
          end else if (valid_q && dirty_q) begin
            pmem_write_d   = 1'b1;
            pmem_address_d = {line_tag_q, {OFFSET_W{1'b0}}};
            pmem_wdata_d   = line_data_q;
            state_d        = WRITEBACK;
`ifdef DMEM_RESP_STATS_EN
            miss_inc = 1'b1;
`endif
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag, {OFFSET_W{1'b0}}};
            state_d        = FILL;
`ifdef DMEM_RESP_STATS_EN
            miss_inc = 1'b1;
`endif
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d        = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_address_d = {req_tag, {OFFSET_W{1'b0}}};
          state_d        = FILL;
        end else begin
          pmem_write_d = 1'b1;
        end
      end

      FILL: begin
        if (pmem_resp) begin
          line_data_d = pmem_rdata;
          line_tag_d  = req_tag;
          valid_d     = 1'b1;
          dirty_d     = 1'b0;
          state_d     = IDLE;
`ifdef DMEM_RESP_STATS_EN
          // The re-lookup after a fill belongs to the miss, not a new hit
          retry_d = 1'b1;
`endif
        end else begin
          pmem_read_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, line buffer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      dmem_rdata   <= '0;
      dmem_resp    <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      dmem_rdata   <= dmem_rdata_d;
      dmem_resp    <= dmem_resp_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
    end
  end

`ifdef DMEM_RESP_STATS_EN
  // Access statistics, free-running with natural 32-bit wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      retry_q <= retry_d;
      if (hit_inc) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_inc) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: misses, hits, write-back, reset abort and byte-masked writes.
module tb_dmem_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         dmem_read, dmem_write;
  logic [31:0]  dmem_address, dmem_wdata;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_rdata;
  logic         dmem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef DMEM_RESP_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  logic overlap = 1'b0;
  int wr_cycles = 0;

  dmem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_wmask   (dmem_wmask),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef DMEM_RESP_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pmem_read && pmem_write) overlap <= 1'b1;
    if (pmem_write) wr_cycles <= wr_cycles + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line-memory model: wait for the strobe, hold for 'delay' cycles, then pulse pmem_resp
  task automatic serve(input bit wr, input logic [31:0] addr, input int delay,
                       input logic [255:0] data, input string tag);
    int n;
    n = 0;
    while (!(wr ? pmem_write : pmem_read) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " strobe"}, wr ? pmem_write : pmem_read, 256'd1);
    chk({tag, " addr"}, pmem_address, addr);
    chk({tag, " other strobe"}, wr ? pmem_read : pmem_write, 256'd0);
    if (wr) chk({tag, " wdata"}, pmem_wdata, data);
    repeat (delay) tick();
    chk({tag, " strobe held"}, wr ? pmem_write : pmem_read, 256'd1);
    if (!wr) pmem_rdata = data;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk({tag, " strobe drop"}, wr ? pmem_write : pmem_read, 256'd0);
  endtask

  task automatic wait_resp(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (!dmem_resp && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " resp"}, dmem_resp, 256'd1);
    chk({tag, " rdata"}, dmem_rdata, exp);
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    tick();
    chk({tag, " resp pulse"}, dmem_resp, 256'd0);
  endtask

  task automatic start_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    dmem_read    = rd;
    dmem_write   = wr;
    dmem_address = addr;
    dmem_wdata   = wdata;
    dmem_wmask   = mask;
  endtask

  // Hit: response must be visible one cycle after the request is presented
  task automatic hit_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask,
                            input logic [31:0] exp, input string tag);
    start_req(rd, wr, addr, wdata, mask);
    tick();
    chk({tag, " hit latency"}, dmem_resp, 256'd1);
    chk({tag, " no pmem"}, {pmem_read, pmem_write}, 256'd0);
    chk({tag, " rdata"}, dmem_rdata, exp);
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    tick();
    chk({tag, " resp pulse"}, dmem_resp, 256'd0);
  endtask

  logic [255:0] line_a, line_b, line_c, line_d, exp_wb;
  int n;

  initial begin
    line_a = '0;
    line_a[31:0]   = 32'hA0A0_A0A0;
    line_a[63:32]  = 32'hDEAD_BEEF;
    line_a[95:64]  = 32'h1122_3344;
    exp_wb = line_a;
    exp_wb[31:0]   = 32'h0000_0005;
    exp_wb[95:64]  = 32'h11BB_CC44;
    line_b = '0;
    line_b[31:0]   = 32'hCAFE_F00D;
    line_b[63:32]  = 32'h0BAD_C0DE;
    line_c = '0;
    line_c[31:0]   = 32'h1234_5678;
    line_d = '0;
    line_d[31:0]   = 32'h5555_0000;

    rst = 1'b0;
    start_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    tick();
    tick();
    chk("reset dmem_resp", dmem_resp, 256'd0);
    chk("reset dmem_rdata", dmem_rdata, 256'd0);
    chk("reset pmem strobes", {pmem_read, pmem_write}, 256'd0);
    chk("reset pmem_address", pmem_address, 256'd0);
    chk("reset pmem_wdata", pmem_wdata, 256'd0);
    rst = 1'b1;
    tick();

    // Cold miss fills line 0x1000
    start_req(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    serve(1'b0, 32'h0000_1000, 3, line_a, "cold fill");
    wait_resp(32'hDEAD_BEEF, "cold read");
    chk("cold no pmem_write", wr_cycles, 256'd0);

    // Masked write hit, then read back; write leaves dmem_rdata alone
    hit_access(1'b0, 1'b1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0110, 32'hDEAD_BEEF, "mask write");
    hit_access(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0, 32'h11BB_CC44, "mask read");
    hit_access(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0005, 4'b1111, 32'h11BB_CC44, "rw as write");
    hit_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0000_0005, "rw readback");

    // Dirty eviction: write-back of merged line then fill
    start_req(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    serve(1'b1, 32'h0000_1000, 2, exp_wb, "evict wb");
    serve(1'b0, 32'h0000_2000, 1, line_b, "evict fill");
    wait_resp(32'hCAFE_F00D, "evict read");

    // Zero-mask write changes nothing but still dirties the line
    hit_access(1'b0, 1'b1, 32'h0000_2004, 32'hFFFF_FFFF, 4'b0000, 32'hCAFE_F00D, "zero mask write");
    hit_access(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'h0BAD_C0DE, "zero mask read");
    start_req(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
    serve(1'b1, 32'h0000_2000, 1, line_b, "zero mask wb");
    serve(1'b0, 32'h0000_3000, 1, line_c, "zero mask fill");
    wait_resp(32'h1234_5678, "zero mask miss");

    // Reset in the middle of a fill aborts it
    start_req(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
    n = 0;
    while (!pmem_read && n < 20) begin
      tick();
      n++;
    end
    chk("abort fill started", pmem_read, 256'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort pmem_read drop", pmem_read, 256'd0);
    chk("abort pmem_address", pmem_address, 256'd0);
    dmem_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_req(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
    serve(1'b0, 32'h0000_5000, 1, line_d, "refill");
    wait_resp(32'h5555_0000, "refill read");
    hit_access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h5555_0000, "hit 1");
    hit_access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h5555_0000, "hit 2");
    hit_access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h5555_0000, "hit 3");
`ifdef DMEM_RESP_STATS_EN
    chk("stats miss_count", miss_count, 256'd1);
    chk("stats hit_count", hit_count, 256'd3);
`endif

    chk("pmem strobe overlap", overlap, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
